// File: rtl/mem_stage_resp.sv
// mem_stage_resp
// ---------------------------------------------------------------------------
// Memory-stage responder placed directly after the EX/MEM pipeline register.
// Takes a request code (00 nop, 01 read, 10 write, 11 illegal) together with
// an address/ALU result, store data and the instruction word. Loads and stores
// are served from an internal word-addressed data memory after a fixed access
// latency. Results and the instruction are presented to the MEM/WB side, and a
// combinational stall holds the upstream register while an access is pending.
//
// Handshake: upstream presents a request on row_i/addr_i/wdata_i/IR_i and
// must keep it unchanged while stall_o is high; the request is consumed on the
// first rising edge at which stall_o is low. Downstream has no back-pressure:
// valid_o marks the single cycle in which wb_data_o/IR_o/err_o carry a result.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   row_i      request code
//   addr_i     byte address (read/write) or ALU result (nop)
//   wdata_i    store data
//   IR_i       instruction accompanying the request
//   stall_o    combinational hold request to the upstream register
//   wb_data_o  load data, passthrough ALU result, or 0 (write / error)
//   IR_o       instruction delivered with wb_data_o
//   valid_o    result qualifier (0 = bubble)
//   err_o      bad address or illegal code, coincident with valid_o
// ---------------------------------------------------------------------------
module mem_stage_resp #(
    parameter int MEM_WORDS = 1024,
    parameter int LAT       = 2,
    parameter int CNT_W     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  row_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] IR_i,
    output logic        stall_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] IR_o,
    output logic        valid_o,
    output logic        err_o
);

    localparam int              AW        = $clog2(MEM_WORDS);
    localparam logic [31:0]     MEM_LIMIT = 32'(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    localparam logic [1:0] ROW_NOP = 2'b00;
    localparam logic [1:0] ROW_RD  = 2'b01;
    localparam logic [1:0] ROW_WR  = 2'b10;
    localparam logic [1:0] ROW_ILL = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Request captured at acceptance; upstream may move on before completion.
    logic [1:0]  cap_row_q;
    logic [31:0] cap_addr_q;
    logic [31:0] cap_wdata_q;
    logic [31:0] cap_ir_q;

    logic [31:0] mem [MEM_WORDS];

    logic          accept;
    logic          done;
    logic          addr_ok;
    logic [AW-1:0] idx;
    logic          mem_we;

    logic [31:0] wb_data_d;
    logic [31:0] ir_d;
    logic        valid_d;
    logic        err_d;

    assign idx     = cap_addr_q[AW+1:2];
    assign addr_ok = (cap_addr_q[1:0] == 2'b00) &&
                     ({2'b00, cap_addr_q[31:2]} < MEM_LIMIT);
    assign accept  = (state_q == IDLE) && ((row_i == ROW_RD) || (row_i == ROW_WR));
    assign done    = (state_q == BUSY) && (cnt_q == '0);

    // Stall drops in the final BUSY cycle so upstream advances on the same
    // edge that completes the access; the stale request seen in that cycle
    // is never re-accepted because BUSY ignores row_i.
    assign stall_o = accept || ((state_q == BUSY) && (cnt_q != '0));

    // A write completing on a reset edge must not reach the memory.
    assign mem_we = done && (cap_row_q == ROW_WR) && addr_ok && !rst_i;

    // Next-state and result logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_o;
        ir_d      = IR_o;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end else begin
                    wb_data_d = (row_i == ROW_ILL) ? 32'h0 : addr_i;
                    ir_d      = IR_i;
                    valid_d   = 1'b1;
                    err_d     = (row_i == ROW_ILL);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    ir_d    = cap_ir_q;
                    valid_d = 1'b1;
                    if (!addr_ok) begin
                        wb_data_d = 32'h0;
                        err_d     = 1'b1;
                    end else if (cap_row_q == ROW_RD) begin
                        wb_data_d = mem[idx];
                    end else begin
                        wb_data_d = 32'h0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_row_q   <= ROW_NOP;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_ir_q    <= '0;
            wb_data_o   <= '0;
            IR_o        <= '0;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_data_o <= wb_data_d;
            IR_o      <= ir_d;
            valid_o   <= valid_d;
            err_o     <= err_d;
            if (accept) begin
                cap_row_q   <= row_i;
                cap_addr_q  <= addr_i;
                cap_wdata_q <= wdata_i;
                cap_ir_q    <= IR_i;
            end
        end
    end

    // Data memory has no reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx] <= cap_wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_stage_resp.sv
// Testbench for mem_stage_resp (LAT = 2, MEM_WORDS = 1024).
module tb_mem_stage_resp;

  logic        clk_i;
  logic        rst_i;
  logic [1:0]  row_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] IR_i;
  logic        stall_o;
  logic [31:0] wb_data_o;
  logic [31:0] IR_o;
  logic        valid_o;
  logic        err_o;

  int n_tests;
  int n_fail;

  mem_stage_resp #(
    .MEM_WORDS(1024),
    .LAT      (2),
    .CNT_W    (4)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .row_i    (row_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .IR_i     (IR_i),
    .stall_o  (stall_o),
    .wb_data_o(wb_data_o),
    .IR_o     (IR_o),
    .valid_o  (valid_o),
    .err_o    (err_o)
  );

  // clock / watchdog
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  row;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ir;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_stall;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=0x%08h req=0x%08h", name, act, exp);
    end
  endtask

  // Present one request, honour stall_o, then check the result cycle.
  task automatic do_op(input vec_t v, input string tag);
    int stalls;
    logic [31:0] hold_d;
    logic [31:0] hold_ir;
    stalls  = 0;
    hold_d  = wb_data_o;
    hold_ir = IR_o;
    row_i   = v.row;
    addr_i  = v.addr;
    wdata_i = v.wdata;
    IR_i    = v.ir;
    #1;
    while (stall_o && stalls < 40) begin
      stalls++;
      @(posedge clk_i);
      #1;
      check({tag, "_busy_valid"}, {31'b0, valid_o}, 32'h0);
      check({tag, "_busy_hold_data"}, wb_data_o, hold_d);
      check({tag, "_busy_hold_ir"}, IR_o, hold_ir);
    end
    @(posedge clk_i);
    #1;
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
    check({tag, "_valid"}, {31'b0, valid_o}, 32'h1);
    check({tag, "_err"}, {31'b0, err_o}, {31'b0, v.exp_err});
    check({tag, "_data"}, wb_data_o, v.exp_data);
    check({tag, "_ir"}, IR_o, v.ir);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Directed vectors, applied back-to-back with upstream honouring stall_o.
    //            row    addr           wdata          ir             exp_data       err  stall
    vecs[0]  = '{2'b00, 32'h0000_1234, 32'h0,         32'h3000_0000, 32'h0000_1234, 1'b0, 0};
    vecs[1]  = '{2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1000_0001, 32'h0,         1'b0, 2};
    vecs[2]  = '{2'b01, 32'h0000_0010, 32'h0,         32'h1000_0002, 32'hDEAD_BEEF, 1'b0, 2};
    vecs[3]  = '{2'b01, 32'h0000_0010, 32'h0,         32'h1000_0003, 32'hDEAD_BEEF, 1'b0, 2};
    vecs[4]  = '{2'b00, 32'h0000_55AA, 32'h0,         32'h1000_0004, 32'h0000_55AA, 1'b0, 0};
    vecs[5]  = '{2'b10, 32'h0000_0014, 32'hCAFE_F00D, 32'h1000_0005, 32'h0,         1'b0, 2};
    vecs[6]  = '{2'b01, 32'h0000_0014, 32'h0,         32'h1000_0006, 32'hCAFE_F00D, 1'b0, 2};
    vecs[7]  = '{2'b10, 32'h0000_0000, 32'h0102_0304, 32'h1000_0007, 32'h0,         1'b0, 2};
    vecs[8]  = '{2'b01, 32'h0000_0013, 32'h0,         32'h1000_0008, 32'h0,         1'b1, 2};
    vecs[9]  = '{2'b10, 32'h0000_1000, 32'h0BAD_0BAD, 32'h1000_0009, 32'h0,         1'b1, 2};
    vecs[10] = '{2'b01, 32'h0000_0000, 32'h0,         32'h1000_000A, 32'h0102_0304, 1'b0, 2};
    vecs[11] = '{2'b11, 32'h0000_0777, 32'h0,         32'h1000_000B, 32'h0,         1'b1, 0};
    vecs[12] = '{2'b00, 32'hFFFF_0000, 32'h0,         32'h1000_000C, 32'hFFFF_0000, 1'b0, 0};
    vecs[13] = '{2'b10, 32'h0000_0FFC, 32'h1357_2468, 32'h1000_000D, 32'h0,         1'b0, 2};
    vecs[14] = '{2'b01, 32'h0000_0FFC, 32'h0,         32'h1000_000E, 32'h1357_2468, 1'b0, 2};
    vecs[15] = '{2'b10, 32'h0000_0002, 32'h7777_7777, 32'h1000_000F, 32'h0,         1'b1, 2};
    vecs[16] = '{2'b01, 32'h0000_0000, 32'h0,         32'h1000_0010, 32'h0102_0304, 1'b0, 2};
    vecs[17] = '{2'b10, 32'h0000_0020, 32'hAAAA_0000, 32'h1000_0011, 32'h0,         1'b0, 2};

    // Reset held two cycles with a read request present.
    rst_i   = 1'b1;
    row_i   = 2'b01;
    addr_i  = 32'h0000_0040;
    wdata_i = 32'h0;
    IR_i    = 32'hFFFF_FFFF;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_ir", IR_o, 32'h0);
    check("rst_valid", {31'b0, valid_o}, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_stall_read", {31'b0, stall_o}, 32'h1);
    rst_i = 1'b0;
    row_i = 2'b00;
    #1;
    check("rst_stall_nop", {31'b0, stall_o}, 32'h0);

    for (int k = 0; k < 18; k++) begin
      do_op(vecs[k], $sformatf("v%0d", k));
    end

    // Reset asserted in the last BUSY cycle of a write: write must be dropped.
    row_i   = 2'b10;
    addr_i  = 32'h0000_0020;
    wdata_i = 32'h0000_0055;
    IR_i    = 32'h2000_0001;
    @(posedge clk_i);
    #1;
    check("rmid_stall_busy", {31'b0, stall_o}, 32'h1);
    @(posedge clk_i);
    #1;
    check("rmid_stall_last", {31'b0, stall_o}, 32'h0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    row_i = 2'b00;
    check("rmid_valid", {31'b0, valid_o}, 32'h0);
    check("rmid_err", {31'b0, err_o}, 32'h0);
    check("rmid_wb_data", wb_data_o, 32'h0);
    check("rmid_ir", IR_o, 32'h0);
    #1;
    check("rmid_idle_stall", {31'b0, stall_o}, 32'h0);
    do_op('{2'b01, 32'h0000_0020, 32'h0, 32'h2000_0002, 32'hAAAA_0000, 1'b0, 2}, "rmid_read");

    // Bubble after a result: valid_o/err_o drop, data and IR hold.
    do_op('{2'b11, 32'h0000_0001, 32'h0, 32'h2000_0003, 32'h0, 1'b1, 0}, "ill2");
    row_i = 2'b01;
    addr_i = 32'h0000_0010;
    IR_i = 32'h2000_0004;
    @(posedge clk_i);
    #1;
    check("bubble_valid", {31'b0, valid_o}, 32'h0);
    check("bubble_err", {31'b0, err_o}, 32'h0);
    check("bubble_ir_hold", IR_o, 32'h2000_0003);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    row_i = 2'b00;
    check("bubble_read_data", wb_data_o, 32'hDEAD_BEEF);
    check("bubble_read_ir", IR_o, 32'h2000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
